// File: rtl/btn_pkg.sv
// Shared definitions for the button-control / countdown display slice.
//   MODE_*  : encodings of the 2-bit mode code `stat`
//   bcd2_t  : two packed BCD digits {tens, ones}
//   bcd2_is_zero : true when both digits are 0
package btn_pkg;

  localparam logic [1:0] MODE_EDIT = 2'd0;
  localparam logic [1:0] MODE_RUN  = 2'd1;
  localparam logic [1:0] MODE_HOLD = 2'd2;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  function automatic logic bcd2_is_zero(input bcd2_t v);
    return (v.tens == 4'd0) && (v.ones == 4'd0);
  endfunction

endpackage

// File: rtl/bcd2_step.sv
// Combinational 2-digit BCD +1 / -1 with wrap (99 -> 00, 00 -> 99).
//   value : current BCD value (digits assumed 0..9)
//   up    : add one
//   down  : subtract one
//   next  : stepped value; up and down together leave value unchanged
module bcd2_step
  import btn_pkg::*;
(
  input  bcd2_t value,
  input  logic  up,
  input  logic  down,
  output bcd2_t next
);

  always_comb begin
    next = value;
    if (up && !down) begin
      if (value.ones == 4'd9) begin
        next.ones = 4'd0;
        next.tens = (value.tens == 4'd9) ? 4'd0 : value.tens + 4'd1;
      end else begin
        next.ones = value.ones + 4'd1;
      end
    end else if (down && !up) begin
      if (value.ones == 4'd0) begin
        next.ones = 4'd9;
        next.tens = (value.tens == 4'd0) ? 4'd9 : value.tens - 4'd1;
      end else begin
        next.ones = value.ones - 4'd1;
      end
    end
  end

endmodule

// File: rtl/countdown_led.sv
// Two-digit BCD countdown timer driving the 8 board LEDs.
//   clk, rst_n : clock, asynchronous active-low reset
//   stat       : mode (0 edit, 1 run, 2/3 hold)
//   inc, dec   : one-cycle pulses adjusting the preset in edit mode
//   led        : {tens, ones} BCD value, or blink pattern once done
//   running    : counting in run mode and not yet done
//   done       : count reached 00; held until stat returns to edit
module countdown_led
  import btn_pkg::*;
#(
  parameter int          TICK        = 50000000,
  parameter int          BLINK       = 12500000,
  parameter logic [7:0]  PRESET_INIT = 8'h10
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] stat,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] led,
  output logic       running,
  output logic       done
);

  localparam int PW = (TICK  > 1) ? $clog2(TICK)  : 1;
  localparam int BW = (BLINK > 1) ? $clog2(BLINK) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK - 1);

  bcd2_t           preset_q, preset_d, preset_nxt;
  bcd2_t           count_q, count_d, count_dec;
  logic [PW-1:0]   presc_q, presc_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_ph_q, blink_ph_d;
  logic            done_q, done_d;
  logic            running_q, running_d;
  logic [7:0]      led_q, led_d;
  logic [1:0]      stat_prev_q;

  bcd2_step u_preset_step (
    .value (preset_q),
    .up    (inc),
    .down  (dec),
    .next  (preset_nxt)
  );

  // Always-decremented count; only used on a tick, and a tick never
  // happens at 00, so the wrap path is never taken here.
  bcd2_step u_count_step (
    .value (count_q),
    .up    (1'b0),
    .down  (1'b1),
    .next  (count_dec)
  );

  always_comb begin
    preset_d    = preset_q;
    count_d     = count_q;
    presc_d     = presc_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    done_d      = done_q;

    if (stat == MODE_EDIT) begin
      preset_d    = preset_nxt;
      count_d     = preset_nxt;
      presc_d     = '0;
      done_d      = 1'b0;
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
    end else if (stat == MODE_RUN && stat_prev_q == MODE_EDIT) begin
      // Entering run: a 00 preset finishes immediately without a tick.
      count_d = preset_q;
      presc_d = '0;
      done_d  = bcd2_is_zero(preset_q);
    end else if (done_q) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end else if (stat == MODE_RUN) begin
      // Covers reaching run via hold with a 00 count.
      if (bcd2_is_zero(count_q)) begin
        done_d = 1'b1;
      end else if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        count_d = count_dec;
        done_d  = bcd2_is_zero(count_dec);
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    running_d = (stat == MODE_RUN) && !done_d;
    led_d     = done_d ? {8{blink_ph_d}} : count_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      preset_q    <= PRESET_INIT;
      count_q     <= PRESET_INIT;
      presc_q     <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      done_q      <= 1'b0;
      running_q   <= 1'b0;
      led_q       <= PRESET_INIT;
      stat_prev_q <= MODE_EDIT;
    end else begin
      preset_q    <= preset_d;
      count_q     <= count_d;
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      done_q      <= done_d;
      running_q   <= running_d;
      led_q       <= led_d;
      stat_prev_q <= stat;
    end
  end

  assign led     = led_q;
  assign running = running_q;
  assign done    = done_q;

endmodule
